// File: rtl/ex_pipe_reg_if.sv
// Decode-to-execute handshake bundle: valid/ready plus the instruction payload.
// The master drives the payload and valid; the slave answers with ready.
interface ex_pipe_reg_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 2,
    parameter int CTRL_W  = 20,
    parameter int REG_W   = 5
);
    logic                      valid;
    logic                      ready;
    logic [CTRL_W-1:0]         ctrl;
    logic [NUM_OPS*DATA_W-1:0] ops;
    logic [DATA_W-1:0]         imm;
    logic [DATA_W-1:0]         next_addr;
    logic [REG_W-1:0]          rd;
    logic [REG_W-1:0]          rt;

    modport master (
        output valid, ctrl, ops, imm, next_addr, rd, rt,
        input  ready
    );

    modport slave (
        input  valid, ctrl, ops, imm, next_addr, rd, rt,
        output ready
    );
endinterface

// File: rtl/ex_pipe_reg.sv
// ID/EX pipeline register with a two-entry skid buffer so that in_ready is a
// pure register output; invalid slots show all-zero control to execute.
module ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 2,
    parameter int CTRL_W  = 20,
    parameter int REG_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    ex_pipe_reg_if.slave        in_if,
    ex_pipe_reg_if.master       out_if,
    output logic [1:0]          occupancy
);

    typedef struct packed {
        logic [CTRL_W-1:0]              ctrl;
        logic [NUM_OPS-1:0][DATA_W-1:0] ops;
        logic [DATA_W-1:0]              imm;
        logic [DATA_W-1:0]              next_addr;
        logic [REG_W-1:0]               rd;
        logic [REG_W-1:0]               rt;
    } payload_t;

    payload_t m_q, s_q, in_pl;
    logic     m_valid, s_valid;
    logic     in_fire, m_free;

    always_comb begin
        in_pl           = '0;
        in_pl.ctrl      = in_if.ctrl;
        in_pl.ops       = in_if.ops;
        in_pl.imm       = in_if.imm;
        in_pl.next_addr = in_if.next_addr;
        in_pl.rd        = in_if.rd;
        in_pl.rt        = in_if.rt;
    end

    // The skid slot is the only thing that can refuse upstream, so ready
    // depends on a flop alone and never on out_ready combinationally.
    assign in_if.ready = ~s_valid;
    assign in_fire     = in_if.valid & ~s_valid;
    assign m_free      = ~m_valid | out_if.ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_free) begin
            if (s_valid) begin
                m_q     <= s_q;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else if (in_fire) begin
                m_q     <= in_pl;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (in_fire) begin
            s_q     <= in_pl;
            s_valid <= 1'b1;
        end
    end

    // Bubbles carry zero control so RegWrite/MemWr/Branch/Jump cannot leak.
    assign out_if.valid     = m_valid;
    assign out_if.ctrl      = m_valid ? m_q.ctrl : '0;
    assign out_if.ops       = m_q.ops;
    assign out_if.imm       = m_q.imm;
    assign out_if.next_addr = m_q.next_addr;
    assign out_if.rd        = m_q.rd;
    assign out_if.rt        = m_q.rt;

    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_ex_pipe_reg.sv
// Directed bench for ex_pipe_reg: default geometry plus a 3x64-bit instance.
module tb_ex_pipe_reg;

    logic clk = 1'b0;
    logic reset, flush;
    logic [1:0] occ0, occ1;
    int errs = 0;
    int nchk = 0;
    logic [31:0] seen[$];

    always #5 clk = ~clk;

    ex_pipe_reg_if #(.DATA_W(32), .NUM_OPS(2), .CTRL_W(20), .REG_W(5)) a_in ();
    ex_pipe_reg_if #(.DATA_W(32), .NUM_OPS(2), .CTRL_W(20), .REG_W(5)) a_out ();
    ex_pipe_reg_if #(.DATA_W(64), .NUM_OPS(3), .CTRL_W(20), .REG_W(5)) b_in ();
    ex_pipe_reg_if #(.DATA_W(64), .NUM_OPS(3), .CTRL_W(20), .REG_W(5)) b_out ();

    ex_pipe_reg #(.DATA_W(32), .NUM_OPS(2), .CTRL_W(20), .REG_W(5)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_if(a_in.slave), .out_if(a_out.master), .occupancy(occ0)
    );

    ex_pipe_reg #(.DATA_W(64), .NUM_OPS(3), .CTRL_W(20), .REG_W(5)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_if(b_in.slave), .out_if(b_out.master), .occupancy(occ1)
    );

    // Record op A of every transfer actually consumed by execute.
    always @(posedge clk)
        if (!reset && a_out.valid && a_out.ready) seen.push_back(a_out.ops[31:0]);

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [19:0] c, input logic [31:0] opa);
        a_in.valid     = v;
        a_in.ctrl      = c;
        a_in.ops       = {32'h0000_0B00 | opa, opa};
        a_in.imm       = opa ^ 32'hFFFF_0000;
        a_in.next_addr = opa + 32'd4;
        a_in.rd        = opa[4:0];
        a_in.rt        = ~opa[4:0];
    endtask

    initial begin
        logic [31:0] exp_q[$];
        reset = 1'b1;
        flush = 1'b0;
        drive_a(1'b0, 20'h0, 32'h0);
        a_out.ready = 1'b1;
        b_in.valid = 1'b0; b_in.ctrl = '0; b_in.ops = '0; b_in.imm = '0;
        b_in.next_addr = '0; b_in.rd = '0; b_in.rt = '0;
        b_out.ready = 1'b1;

        // Reset then idle
        step(); step();
        reset = 1'b0;
        chk("rst_valid", a_out.valid, 0);
        chk("rst_ctrl", a_out.ctrl, 0);
        chk("rst_ready", a_in.ready, 1);
        chk("rst_occ", occ0, 0);
        chk("rst_ops", a_out.ops, 0);
        step();
        chk("idle_occ", occ0, 0);

        // Streaming at full rate
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 20'(i + 1), 32'h10 + 32'(i));
            step();
            chk($sformatf("st_valid%0d", i), a_out.valid, 1);
            chk($sformatf("st_opa%0d", i), a_out.ops[31:0], 32'h10 + 32'(i));
            chk($sformatf("st_opb%0d", i), a_out.ops[63:32], 32'h0000_0B10 + 32'(i));
            chk($sformatf("st_occ%0d", i), occ0, 1);
        end
        chk("st_next", a_out.next_addr, 32'h17);
        chk("st_rd", a_out.rd, 5'h13);
        drive_a(1'b0, 20'h0, 32'h0);
        step();
        chk("st_drain_valid", a_out.valid, 0);
        chk("st_drain_occ", occ0, 0);
        chk("st_count", seen.size(), 4);

        // Back-pressure fills the skid slot
        seen.delete();
        a_out.ready = 1'b0;
        drive_a(1'b1, 20'h1, 32'hAA);
        step();
        chk("bp_occ1", occ0, 1);
        chk("bp_ready1", a_in.ready, 1);
        drive_a(1'b1, 20'h2, 32'hBB);
        step();
        chk("bp_occ2", occ0, 2);
        chk("bp_ready2", a_in.ready, 0);
        drive_a(1'b1, 20'h3, 32'hCC);
        step();
        chk("bp_hold_occ", occ0, 2);
        chk("bp_hold_head", a_out.ops[31:0], 32'hAA);
        a_out.ready = 1'b1;
        step();
        chk("bp_head_bb", a_out.ops[31:0], 32'hBB);
        chk("bp_ready_back", a_in.ready, 1);
        step();
        chk("bp_head_cc", a_out.ops[31:0], 32'hCC);
        drive_a(1'b0, 20'h0, 32'h0);
        step(); step();
        exp_q = '{32'hAA, 32'hBB, 32'hCC};
        chk("bp_count", seen.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < seen.size()) chk($sformatf("bp_order%0d", i), seen[i], exp_q[i]);
        chk("bp_empty", occ0, 0);

        // Flush with a full buffer and a valid input in the same cycle
        seen.delete();
        a_out.ready = 1'b0;
        drive_a(1'b1, 20'h5, 32'h55); step();
        drive_a(1'b1, 20'h6, 32'h66); step();
        chk("fl_full", occ0, 2);
        flush = 1'b1;
        drive_a(1'b1, 20'hD, 32'hDD);
        step();
        flush = 1'b0;
        drive_a(1'b0, 20'h0, 32'h0);
        chk("fl_valid", a_out.valid, 0);
        chk("fl_ctrl", a_out.ctrl, 0);
        chk("fl_occ", occ0, 0);
        chk("fl_ready", a_in.ready, 1);
        a_out.ready = 1'b1;
        step(); step();
        chk("fl_nothing_out", seen.size(), 0);

        // Bubble masking of control
        drive_a(1'b1, 20'hFFFFF, 32'h77);
        step();
        chk("bub_ctrl_live", a_out.ctrl, 20'hFFFFF);
        drive_a(1'b0, 20'hFFFFF, 32'h0);
        step();
        chk("bub_ctrl_zero", a_out.ctrl, 0);
        chk("bub_valid", a_out.valid, 0);

        // Reset in the middle of a stall
        a_out.ready = 1'b0;
        drive_a(1'b1, 20'h1, 32'h31); step();
        drive_a(1'b1, 20'h2, 32'h32); step();
        chk("rs_full", occ0, 2);
        reset = 1'b1;
        drive_a(1'b0, 20'h0, 32'h0);
        step();
        reset = 1'b0;
        chk("rs_occ", occ0, 0);
        chk("rs_valid", a_out.valid, 0);
        chk("rs_ready", a_in.ready, 1);
        a_out.ready = 1'b1;

        // Wide geometry: three 64-bit operands pass untouched
        b_in.valid = 1'b1;
        b_in.ctrl  = 20'hABCDE;
        b_in.ops   = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001};
        b_in.imm   = 64'hFFFF_FFFF_FFFF_FFF0;
        step();
        b_in.valid = 1'b0;
        chk("w_valid", b_out.valid, 1);
        chk("w_op2", b_out.ops[191:128], 64'h0123_4567_89AB_CDEF);
        chk("w_op1", b_out.ops[127:64], 64'hFEDC_BA98_7654_3210);
        chk("w_op0", b_out.ops[63:0], 64'h8000_0000_0000_0001);
        chk("w_imm", b_out.imm, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("w_occ", occ1, 1);
        step();
        chk("w_drain", occ1, 0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/ex_pipe_reg.md
Name: ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register with a ready/valid handshake and a 2-entry skid buffer, so upstream back-pressure is registered.
- Adds stall, flush and bubble behaviour: invalid slots present all-zero control, so RegWrite/MemWr/Branch/Jump of a bubble are 0.
- Sits between decode and the execute datapath (ALU, Rw mux, branch-target adder); carries control bits, NUM_OPS operand buses, immediate, next address and register specifiers.

Parameters:
- DATA_W, 32, width of each operand, immediate and next-address field
- NUM_OPS, 2, number of operand buses (BusA, BusB, ...)
- CTRL_W, 20, width of packed control vector (RegDst, ALUSrc, MemToReg, RegWrite, MemWr, Branch, Jump, AluCtrl[3:0], FPoint[1:0], Dsize[1:0], Loadext, Jal, Jar, spare)
- REG_W, 5, width of each register specifier (Rd, Rt)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held entries (branch/jump redirect)
- in_valid  in  1  decode presents a valid instruction
- in_ready  out  1  stage can accept; registered, equals ~skid_valid
- in_ctrl  in  CTRL_W  control vector
- in_ops  in  NUM_OPS*DATA_W  operand buses; op k at bits [k*DATA_W +: DATA_W]
- in_imm  in  DATA_W  sign-extended immediate
- in_next  in  DATA_W  next sequential address
- in_rd, in_rt  in  REG_W each  destination specifiers
- out_valid  out  1  execute-side entry valid
- out_ready  in  1  execute/memory can consume
- out_ctrl, out_ops, out_imm, out_next, out_rd, out_rt  out  same widths  held payload
- occupancy  out  2  entries held (0, 1 or 2)

Behaviour:
- Storage: main register M (drives out_*) and skid register S; each with a valid bit.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset: M.valid = S.valid = 0. All payload registers = 0. in_ready = 1, occupancy = 0.
- Priority order: reset > flush > normal.
- Flush, next cycle:
  - M.valid = S.valid = 0; in_ready = 1.
  - The input presented in the flush cycle is dropped even if in_valid = 1.
  - Payload registers are left unchanged.
- Normal operation, M slot free (M.valid = 0 or out_fire):
  - If S.valid: M <= S, S.valid <= 0. The input is not sampled, because in_ready = 0 whenever S.valid = 1.
  - Else if in_fire: M <= input, M.valid <= 1.
  - Else: M.valid <= 0.
- Normal operation, M slot held (M.valid = 1 and ~out_ready):
  - If in_fire: S <= input, S.valid <= 1.
  - M is unchanged.
- Latency: 1 cycle from in_fire to out_valid when empty. Throughput: 1 per cycle while out_ready = 1.
- Simultaneous in_fire and out_fire with S empty: M replaced by the new input. No bubble, no loss.
- Full (S.valid = 1): in_ready = 0. Any in_valid is ignored without loss; the source must hold.
- Bubble masking: out_ctrl = M.ctrl when M.valid, else all zeros. Other out_* always show M payload (don't-care when invalid).
- occupancy = M.valid + S.valid (2-bit sum, max 2).
- Payload is an opaque bit-copy: no sign or width conversion, ops packed little-end first.
- Reset asserted mid-transfer: both entries are lost, identical to the reset state next cycle.

Test Plan:
- Reset then idle: hold reset 2 cycles -> out_valid = 0, out_ctrl = 0, in_ready = 1, occupancy = 0.
- Streaming: 4 consecutive in_valid with ops A = 0x10..0x13, out_ready = 1 -> out_valid from cycle 1, out_ops A = 0x10,0x11,0x12,0x13 on consecutive cycles, occupancy never > 1.
- Back-pressure:
  - out_ready = 0 while sending 0xAA then 0xBB -> occupancy = 2, in_ready = 0, 0xCC held off.
  - Then out_ready = 1 -> 0xAA, 0xBB, 0xCC emitted in order, none lost or duplicated.
- Flush with full buffer: occupancy = 2, assert flush with in_valid = 1 (0xDD) -> next cycle out_valid = 0, out_ctrl = 0, occupancy = 0, in_ready = 1; 0xDD never appears.
- Bubble masking: in_ctrl = 0xFFFFF then idle with out_ready = 1 -> out_ctrl = 0xFFFFF for one cycle, then 0x00000.
- Parameter sweep: NUM_OPS = 3, DATA_W = 64 with op2 = 0x0123456789ABCDEF -> appears unchanged at out_ops[191:128]. Reset mid-stall -> occupancy = 0 next cycle.
